// File: rtl/edge_track_pkg.sv
// Shared widths, FSM encoding and bounding-box record for the edge tracker
// and any other overlay stage that follows the Sobel pipeline.
package edge_track_pkg;

  localparam int DEF_LINE_WIDTH   = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam int X_W   = $clog2(DEF_LINE_WIDTH);
  localparam int Y_W   = $clog2(DEF_FRAME_HEIGHT);
  localparam int CNT_W = 19;
  localparam int OUT_W = 10;

  typedef enum logic {ARMED, ACCUM} trk_state_e;

  typedef struct packed {
    logic [X_W-1:0] xmin;
    logic [X_W-1:0] xmax;
    logic [Y_W-1:0] ymin;
    logic [Y_W-1:0] ymax;
  } bbox_t;

  // Min fields start at all-ones so the first edge pixel always wins.
  localparam bbox_t BBOX_EMPTY = '{xmin: '1, xmax: '0, ymin: '1, ymax: '0};

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/edge_bbox_tracker_if.sv
// Video stream into and out of the bbox tracker: syncs, blank and pixel,
// with the 1-cycle delayed copies on the output side.
interface edge_bbox_tracker_if #(
  parameter int PIXEL_DEPTH = 8
);
  logic                   vs_ni;
  logic                   hs_ni;
  logic                   blank_ni;
  logic [PIXEL_DEPTH-1:0] edge_i;
  logic                   vs_no;
  logic                   hs_no;
  logic                   blank_no;
  logic [PIXEL_DEPTH-1:0] pixel_o;

  modport master (
    output vs_ni, hs_ni, blank_ni, edge_i,
    input  vs_no, hs_no, blank_no, pixel_o
  );

  modport slave (
    input  vs_ni, hs_ni, blank_ni, edge_i,
    output vs_no, hs_no, blank_no, pixel_o
  );
endinterface

// File: rtl/edge_bbox_tracker_video_pos_counter.sv
// Pixel position tracker driven only by vsync/blank; x/y are the coordinates
// of the pixel presented on the current cycle.
module video_pos_counter #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int XW           = 10,
  parameter int YW           = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs_ni,
  input  logic          blank_ni,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          line_end_o,
  output logic          frame_end_o
);

  logic          vs_d_q, blank_d_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  assign line_end_o  = blank_d_q & ~blank_ni;
  assign frame_end_o = vs_d_q & ~vs_ni;
  assign x_o = x_q;
  assign y_o = y_q;

  always_comb begin
    x_d = '0;
    if (blank_ni)
      x_d = (x_q == XW'(LINE_WIDTH - 1)) ? x_q : x_q + XW'(1);
    y_d = y_q;
    // Frame end wins so a line end on the same cycle cannot leak into y.
    if (frame_end_o)
      y_d = '0;
    else if (line_end_o && (y_q != YW'(FRAME_HEIGHT - 1)))
      y_d = y_q + YW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_q    <= 1'b1;
      blank_d_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      vs_d_q    <= vs_ni;
      blank_d_q <= blank_ni;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

endmodule

// File: rtl/edge_bbox_tracker.sv
// Accumulates the bounding box and count of edge pixels per frame, latches
// them at each vsync fall and optionally borders the video with last frame's box.
module edge_bbox_tracker
  import edge_track_pkg::*;
#(
  parameter int                     LINE_WIDTH   = 640,
  parameter int                     FRAME_HEIGHT = 480,
  parameter int                     PIXEL_DEPTH  = 8,
  parameter int                     EDGE_MIN     = 128,
  parameter int                     MIN_PIXELS   = 64,
  parameter logic [PIXEL_DEPTH-1:0] BOX_COLOR    = PIXEL_DEPTH'(8'h80)
) (
  input  logic              clk,
  input  logic              rst_n,
  edge_bbox_tracker_if.slave vid,
  input  logic              overlay_en,
  output logic [OUT_W-1:0]  bbox_xmin,
  output logic [OUT_W-1:0]  bbox_xmax,
  output logic [OUT_W-1:0]  bbox_ymin,
  output logic [OUT_W-1:0]  bbox_ymax,
  output logic [CNT_W-1:0]  edge_count,
  output logic              bbox_valid,
  output logic              frame_done
);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           line_end, frame_end;

  video_pos_counter #(
    .LINE_WIDTH  (LINE_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .XW          (X_W),
    .YW          (Y_W)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs_ni      (vid.vs_ni),
    .blank_ni   (vid.blank_ni),
    .x_o        (x),
    .y_o        (y),
    .line_end_o (line_end),
    .frame_end_o(frame_end)
  );

  trk_state_e       state_q, state_d;
  logic             latch, clr, hit;
  bbox_t            run_q, close_v, box_q;
  logic [CNT_W-1:0] run_cnt_q, close_cnt, count_q;
  logic             valid_q, done_q;

  assign hit = vid.blank_ni && (vid.edge_i >= PIXEL_DEPTH'(EDGE_MIN));

  // Running values including the current pixel; a hit on the vsync-fall
  // cycle therefore lands in the latched result, not the new frame.
  always_comb begin
    close_v   = run_q;
    close_cnt = run_cnt_q;
    if (hit) begin
      if (x < run_q.xmin) close_v.xmin = x;
      if (x > run_q.xmax) close_v.xmax = x;
      if (y < run_q.ymin) close_v.ymin = y;
      if (y > run_q.ymax) close_v.ymax = y;
      close_cnt = cnt_inc_sat(run_cnt_q);
    end
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ARMED: if (frame_end) begin
        clr     = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: if (frame_end) begin
        latch = 1'b1;
        clr   = 1'b1;
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARMED;
      run_q     <= BBOX_EMPTY;
      run_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        run_q     <= BBOX_EMPTY;
        run_cnt_q <= '0;
      end else begin
        run_q     <= close_v;
        run_cnt_q <= close_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= latch;
      if (latch) begin
        box_q   <= (close_cnt == '0) ? '0 : close_v;
        count_q <= close_cnt;
        valid_q <= (close_cnt >= CNT_W'(MIN_PIXELS));
      end
    end
  end

  logic                   on_col, on_row, border;
  logic [PIXEL_DEPTH-1:0] pix_d, pix_q;
  logic                   vs_q, hs_q, blank_q;

  always_comb begin
    on_col = ((x == box_q.xmin) || (x == box_q.xmax)) &&
             (y >= box_q.ymin) && (y <= box_q.ymax);
    on_row = ((y == box_q.ymin) || (y == box_q.ymax)) &&
             (x >= box_q.xmin) && (x <= box_q.xmax);
    border = valid_q && overlay_en && (on_col || on_row);
    pix_d  = '0;
    if (vid.blank_ni)
      pix_d = border ? BOX_COLOR : vid.edge_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b1;
      hs_q    <= 1'b1;
      blank_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      vs_q    <= vid.vs_ni;
      hs_q    <= vid.hs_ni;
      blank_q <= vid.blank_ni;
      pix_q   <= pix_d;
    end
  end

  assign vid.vs_no    = vs_q;
  assign vid.hs_no    = hs_q;
  assign vid.blank_no = blank_q;
  assign vid.pixel_o  = pix_q;

  assign bbox_xmin  = OUT_W'(box_q.xmin);
  assign bbox_xmax  = OUT_W'(box_q.xmax);
  assign bbox_ymin  = OUT_W'(box_q.ymin);
  assign bbox_ymax  = OUT_W'(box_q.ymax);
  assign edge_count = count_q;
  assign bbox_valid = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// Frame-level bench for edge_bbox_tracker on a reduced 64x32 raster.
module tb_edge_bbox_tracker;
  localparam int LW  = 64;
  localparam int FH  = 32;
  localparam int HBL = 6;
  localparam logic [7:0] BOX = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic overlay_en = 1'b0;
  logic [9:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic [18:0] edge_count;
  logic        bbox_valid, frame_done;

  always #5 clk = ~clk;

  edge_bbox_tracker_if #(.PIXEL_DEPTH(8)) vid ();

  edge_bbox_tracker #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH)) dut (
    .clk(clk), .rst_n(rst_n), .vid(vid), .overlay_en(overlay_en),
    .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
    .edge_count(edge_count), .bbox_valid(bbox_valid), .frame_done(frame_done)
  );

  typedef struct {
    string      name;
    int         x0, x1, y0, y1;
    logic [7:0] fg, bg;
    bit         ov, vs_last, wide;
    int         rst_line;
    bit         exp_done;
    int         exmin, exmax, eymin, eymax, ecnt;
    bit         evalid;
    int         eborder;
  } vec_t;

  typedef struct {
    string name;
    int    xmin, xmax, ymin, ymax, cnt, valid;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, border_cnt = 0, bad_cnt = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void chk_reset(string t);
    chk({t, "_vs_no"}, int'(vid.vs_no), 1);
    chk({t, "_hs_no"}, int'(vid.hs_no), 1);
    chk({t, "_blank_no"}, int'(vid.blank_no), 0);
    chk({t, "_pixel_o"}, int'(vid.pixel_o), 0);
    chk({t, "_xmin"}, int'(bbox_xmin), 0);
    chk({t, "_xmax"}, int'(bbox_xmax), 0);
    chk({t, "_ymin"}, int'(bbox_ymin), 0);
    chk({t, "_ymax"}, int'(bbox_ymax), 0);
    chk({t, "_count"}, int'(edge_count), 0);
    chk({t, "_valid"}, int'(bbox_valid), 0);
    chk({t, "_done"}, int'(frame_done), 0);
  endfunction

  function automatic void push_exp(vec_t f);
    exp_t e;
    if (f.exp_done) begin
      e = '{f.name, f.exmin, f.exmax, f.eymin, f.eymax, f.ecnt, int'(f.evalid)};
      sb_q.push_back(e);
    end
  endfunction

  // Output monitor: scoreboard on frame_done, pass-through/latency sanity
  // and border-pixel counting, sampled 1 time unit after the active edge.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (rst_n) begin
      if (frame_done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_xmin"}, int'(bbox_xmin), e.xmin);
          chk({e.name, "_xmax"}, int'(bbox_xmax), e.xmax);
          chk({e.name, "_ymin"}, int'(bbox_ymin), e.ymin);
          chk({e.name, "_ymax"}, int'(bbox_ymax), e.ymax);
          chk({e.name, "_count"}, int'(edge_count), e.cnt);
          chk({e.name, "_valid"}, int'(bbox_valid), e.valid);
        end
      end
      if (vid.vs_no != vid.vs_ni || vid.hs_no != vid.hs_ni || vid.blank_no != vid.blank_ni)
        bad_cnt++;
      else if (!vid.blank_ni && vid.pixel_o != 8'h00)
        bad_cnt++;
      else if (vid.blank_ni && vid.pixel_o != vid.edge_i && vid.pixel_o != BOX)
        bad_cnt++;
      if (vid.blank_no && vid.pixel_o == BOX && vid.edge_i != BOX)
        border_cnt++;
    end
  end

  task automatic drive_frame(input vec_t f);
    int d0;
    d0 = done_cnt;
    border_cnt = 0;
    bad_cnt = 0;
    overlay_en = f.ov;
    for (int yy = 0; yy < FH; yy++) begin
      int len;
      len = (f.wide && yy == 0) ? LW + 6 : LW;
      for (int xx = 0; xx < len; xx++) begin
        @(negedge clk);
        vid.blank_ni = 1'b1;
        vid.hs_ni    = 1'b1;
        vid.edge_i   = (xx >= f.x0 && xx <= f.x1 && yy >= f.y0 && yy <= f.y1) ? f.fg : f.bg;
        if (f.vs_last && yy == FH - 1 && xx == len - 1) begin
          push_exp(f);
          vid.vs_ni = 1'b0;
        end
        if (yy == f.rst_line && xx == LW / 2) begin
          rst_n = 1'b0;
          #1;
          chk_reset({f.name, "_async"});
        end
        if (yy == f.rst_line && xx == LW / 2 + 3) rst_n = 1'b1;
      end
      for (int h = 0; h < HBL; h++) begin
        @(negedge clk);
        vid.blank_ni = 1'b0;
        vid.edge_i   = 8'h00;
        vid.hs_ni    = !(h >= 2 && h < 4);
      end
    end
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      if (v == 0 && !f.vs_last) push_exp(f);
      vid.vs_ni = (v >= 8);
    end
    chk({f.name, "_done_pulses"}, done_cnt - d0, int'(f.exp_done));
    chk({f.name, "_border_px"}, border_cnt, f.eborder);
    chk({f.name, "_stream_errs"}, bad_cnt, 0);
  endtask

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //         name          x0 x1 y0 y1  fg     bg     ov vsl wd rst done xmn xmx ymn ymx cnt val brd
    vecs[0]  = '{"arm",      10,10, 5, 5, 8'hff, 8'h00, 0, 0, 0, -1, 0,   0,  0,  0,  0,  0, 0,  0};
    vecs[1]  = '{"single",   10,10, 5, 5, 8'hff, 8'h00, 0, 0, 0, -1, 1,  10, 10,  5,  5,  1, 0,  0};
    vecs[2]  = '{"rect_thr", 20,39, 3,12, 8'h80, 8'h7f, 1, 0, 0, -1, 1,  20, 39,  3, 12,200, 1,  0};
    vecs[3]  = '{"rect_ovoff",20,39,3,12, 8'hff, 8'h00, 0, 0, 0, -1, 1,  20, 39,  3, 12,200, 1,  0};
    vecs[4]  = '{"rst_mid",  20,39, 3,12, 8'hff, 8'h00, 1, 0, 0, 16, 0,   0,  0,  0,  0,  0, 0, 56};
    vecs[5]  = '{"rearm",    20,39, 3,12, 8'hff, 8'h00, 1, 0, 0, -1, 1,  20, 39,  3, 12,200, 1,  0};
    vecs[6]  = '{"zero_ov",   1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, -1, 1,   0,  0,  0,  0,  0, 0, 56};
    vecs[7]  = '{"zero_next", 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, -1, 1,   0,  0,  0,  0,  0, 0,  0};
    vecs[8]  = '{"corner",   63,63,31,31, 8'hff, 8'h00, 0, 1, 0, -1, 1,  63, 63, 31, 31,  1, 0,  0};
    vecs[9]  = '{"fresh",     1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, -1, 1,   0,  0,  0,  0,  0, 0,  0};
    vecs[10] = '{"xsat",      0,69, 0, 0, 8'hff, 8'h00, 0, 0, 1, -1, 1,   0, 63,  0,  0, 70, 1,  0};
    vecs[11] = '{"xsat_ov",   1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, -1, 1,   0,  0,  0,  0,  0, 0, 64};

    vid.vs_ni = 1'b1; vid.hs_ni = 1'b1; vid.blank_ni = 1'b0; vid.edge_i = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) drive_frame(vecs[i]);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/edge_bbox_tracker.md
# edge_bbox_tracker

Downstream stage of the Sobel edge detector. Consumes the binary edge stream plus its delayed sync/blank signals, tracks pixel position, and accumulates the bounding box and count of edge pixels over each frame. At every frame boundary it latches the result. On the following frame it can draw that box as a 1-pixel border over the edge video before the VGA output.

## Interface
Parameters:
- LINE_WIDTH, 640: active pixels per line.
- FRAME_HEIGHT, 480: active lines per frame.
- PIXEL_DEPTH, 8: edge/output pixel width.
- EDGE_MIN, 128: edge_i ≥ EDGE_MIN counts as an edge pixel.
- MIN_PIXELS, 64: minimum edge count for a valid box.
- BOX_COLOR, 8'h80: overlay border value.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- vs_ni  in  1  vertical sync, active low.
- hs_ni  in  1  horizontal sync, active low.
- blank_ni  in  1  1 = active video.
- edge_i  in  PIXEL_DEPTH  edge magnitude pixel (0 or 8'hff from upstream).
- overlay_en  in  1  enables drawing of the box border.
- vs_no, hs_no, blank_no  out  1 each  syncs delayed 1 cycle.
- pixel_o  out  PIXEL_DEPTH  overlaid video.
- bbox_xmin, bbox_xmax  out  10  latched box columns.
- bbox_ymin, bbox_ymax  out  10  latched box rows.
- edge_count  out  19  latched edge-pixel count of the last frame.
- bbox_valid  out  1  latched box meets MIN_PIXELS.
- frame_done  out  1  one-cycle pulse when a result is latched.

## Operation
- Position counters:
  - x increments on each cycle with blank_ni=1 and clears on cycles with blank_ni=0.
  - y increments on the blank_ni 1→0 transition (line end) and clears on the vs_ni 1→0 transition (frame end).
  - Both saturate at LINE_WIDTH-1 and FRAME_HEIGHT-1.
- Accumulators: run_xmin/ymin initialise to the all-ones maximum and run_xmax/ymax to 0. On each active cycle with edge_i ≥ EDGE_MIN:
  - update min/max with the current x,y;
  - increment run_count, saturating at 2^19-1.
- FSM, package enum:
  - ARMED: entered from reset. On the first vs_ni fall, clear the accumulators and go to ACCUM. No frame_done pulse; the partial frame is discarded.
  - ACCUM: on each vs_ni fall, do the following in the same cycle, then stay in ACCUM:
    - latch run_* into the bbox_* outputs and edge_count;
    - set bbox_valid = (run_count ≥ MIN_PIXELS);
    - pulse frame_done;
    - re-initialise the accumulators.
- Zero-edge frame: bbox_* latch as 0, edge_count=0, bbox_valid=0.
- Simultaneous events: an edge pixel on the same cycle as the vs_ni fall belongs to the closing frame. It is folded into the latched values, not the new accumulators.
- Overlay: a pixel is on the border when bbox_valid && overlay_en and either of these holds:
  - (x==xmin || x==xmax) with ymin≤y≤ymax;
  - (y==ymin || y==ymax) with xmin≤x≤xmax.
- pixel_o = BOX_COLOR on the border, otherwise edge_i. pixel_o is forced to 0 when blank_ni=0.
- The border uses the previous frame's latched box, never the running one.

## Timing
- Reset values:
  - vs_no=1, hs_no=1, blank_no=0, pixel_o=0;
  - all bbox_*=0, edge_count=0, bbox_valid=0, frame_done=0;
  - FSM=ARMED, x=y=0.
- Video path latency is exactly 1 cycle. pixel_o is aligned with vs_no/hs_no/blank_no.
- The latched outputs update on the clock edge that samples the vs_ni fall. frame_done is high for that one following cycle only.
- Edge detection on vs_ni and blank_ni uses 1-cycle delayed copies, which are reset to 1 and 0 respectively.
- Reset mid-frame: everything clears asynchronously and the FSM returns to ARMED. The next complete frame is the first reported.

## Structure
- edge_track_pkg holds:
  - X_W=$clog2(LINE_WIDTH) and Y_W=$clog2(FRAME_HEIGHT);
  - CNT_W=19;
  - the FSM enum {ARMED, ACCUM};
  - a bbox_t struct {xmin, xmax, ymin, ymax}.
- Sub-module video_pos_counter takes vs_ni/blank_ni and produces x, y, line_end and frame_end pulses. It is reusable by other overlay stages.

## Test plan
- Reset, then one 640×480 frame with a single edge pixel at (100,50). Required: no frame_done (ARMED). Second identical frame: frame_done, bbox=(100,100,50,50), edge_count=1, bbox_valid=0.
- Filled 20×10 edge rectangle at x 200–219, y 30–39. Required: bbox=(200,219,30,39), edge_count=200, bbox_valid=1. The next frame outputs BOX_COLOR on exactly 56 border pixels with overlay_en=1, and none with overlay_en=0.
- All-zero frame after a valid frame. Required: bbox_*=0, edge_count=0, bbox_valid=0; the next frame has no overlay.
- Edge pixel driven on the exact vs_ni falling cycle at x=639,y=479. Required: it is included in the latched box (xmax=639, ymax=479). The new accumulators start empty.
- Assert rst_n low for 3 cycles at line 240 of an ACCUM frame. Required: all outputs return to their reset values immediately. The first frame_done occurs only after one discarded frame.
- Blank held high for 700 cycles. Required: x saturates at 639, no wrap, and bbox_xmax ≤ 639.
